// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mult_div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic logic [WIDTH-1:0] abs_f(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Applies operand signs to the magnitude result and splits it into HI/LO.
module sign_fix
  import mult_div_pkg::*;
(
  input  logic               op_i,
  input  logic               sign_a_i,
  input  logic               sign_b_i,
  input  logic               b_zero_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [WIDTH-1:0]   rem_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic               neg;
  logic [2*WIDTH-1:0] prod_s;

  always_comb begin
    neg    = sign_a_i ^ sign_b_i;
    prod_s = neg ? -prod_i : prod_i;
    hi_o   = prod_s[2*WIDTH-1:WIDTH];
    lo_o   = prod_s[WIDTH-1:0];
    if (op_i == OP_DIV) begin
      // remainder follows the dividend; with b==0 it equals |a|, so HI = a
      hi_o = sign_a_i ? -rem_i : rem_i;
      lo_o = b_zero_i ? '1 : (neg ? -quo_i : quo_i);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Radix-2 signed mult/div owning HI/LO; one bit per cycle.
// Optional MULTDIV_DIV0_EXC_EN: divide by zero completes early with div0.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_q, sa_q, sb_q, bz_q;
  logic [WIDTH-1:0]   mag_q, rem_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] acc_mul, acc_div;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   rem_div;

  // mult: add multiplicand into upper half when multiplier LSB is set
  assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign acc_mul = {msum, acc_q[WIDTH-1:1]};

  // div: restoring step, dividend bits shift out as quotient bits shift in
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b0, mag_q};
  assign rem_div = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign acc_div = {acc_q[2*WIDTH-1:WIDTH],
                    acc_q[WIDTH-2:0], ~diff[WIDTH+1]};

  sign_fix u_sign_fix (
    .op_i     (op_q),
    .sign_a_i (sa_q),
    .sign_b_i (sb_q),
    .b_zero_i (bz_q),
    .prod_i   (acc_q),
    .quo_i    (acc_q[WIDTH-1:0]),
    .rem_i    (rem_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

`ifdef MULTDIV_DIV0_EXC_EN
  logic div0_q;
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      mag_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULTDIV_DIV0_EXC_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULTDIV_DIV0_EXC_EN
      div0_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sa_q   <= a[WIDTH-1];
            sb_q   <= b[WIDTH-1];
            bz_q   <= (op == OP_DIV) && (b == '0);
            cnt_q  <= '0;
            rem_q  <= '0;
            busy_q <= 1'b1;
            if (op == OP_MULT) begin
              mag_q <= abs_f(a);
              acc_q <= {{WIDTH{1'b0}}, abs_f(b)};
            end else begin
              mag_q <= abs_f(b);
              acc_q <= {{WIDTH{1'b0}}, abs_f(a)};
            end
`ifdef MULTDIV_DIV0_EXC_EN
            if ((op == OP_DIV) && (b == '0)) state_q <= FIX;
            else                             state_q <= CALC;
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == OP_MULT) begin
            acc_q <= acc_mul;
          end else begin
            acc_q <= acc_div;
            rem_q <= rem_div;
          end
          if (cnt_q == ITER_LAST) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef MULTDIV_DIV0_EXC_EN
          if (bz_q) begin
            div0_q <= 1'b1;
          end else begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
`else
          hi_q <= fix_hi;
          lo_q <= fix_lo;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: signed mult/div, div by zero,
// ignored start while busy, and mid-operation reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div0    (div0),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start, waits for done, checks result.
  task automatic run(input logic op_v, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] eh,
                     input logic [31:0] el, input int ecyc,
                     input logic ediv0, input bit btb,
                     input string tag);
    int cyc;
    op = op_v; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    chk({tag, ".done_early"}, 64'(done), 64'd0);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(ecyc));
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
    chk({tag, ".div0"}, 64'(div0), 64'(ediv0));
    if (!btb) begin
      @(negedge clk);
      chk({tag, ".done_pulse"}, 64'(done), 64'd0);
      chk({tag, ".busy_end"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int          cyc, dones;
    logic [31:0] sh, sl;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.div0", 64'(div0), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
        34, 1'b0, 1'b0, "mul_7_m3");
    run(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,
        32'h0000_0000, 34, 1'b0, 1'b0, "mul_min_min");
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
        34, 1'b0, 1'b1, "div_m7_2");
    // started in the cycle the previous done is high
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD,
        34, 1'b0, 1'b0, "div_7_m2");
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
        32'h8000_0000, 34, 1'b0, 1'b0, "div_min_m1");
    run(1'b1, 32'd100, 32'd7, 32'd2, 32'd14,
        34, 1'b0, 1'b0, "div_100_7");
    run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14,
        34, 1'b0, 1'b0, "div_m100_m7");
`ifdef MULTDIV_DIV0_EXC_EN
    run(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFE, 32'd14,
        2, 1'b1, 1'b0, "div0_exc");
`else
    run(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF,
        34, 1'b0, 1'b0, "div0_full");
`endif

    // extra start pulses while busy must be ignored
    op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 1'b1; a = 32'd100; b = 32'd3;
    cyc = 1; dones = 0; sh = '0; sl = '0;
    repeat (45) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        dones++;
        sh = hi;
        sl = lo;
      end
      start = (cyc == 5 || cyc == 20);
    end
    start = 1'b0;
    chk("busy_start.dones", 64'(dones), 64'd1);
    chk("busy_start.hi", 64'(sh), 64'hFFFF_FFFF);
    chk("busy_start.lo", 64'(sl), 64'hFFFF_FFEB);
    chk("busy_start.idle", 64'(busy), 64'd0);

    // reset in the middle of a divide
    op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.done", 64'(done), 64'd0);
    chk("rst_mid.hi", 64'(hi), 64'd0);
    chk("rst_mid.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid.no_done", 64'(dones), 64'd0);
    chk("rst_mid.hi_hold", 64'(hi), 64'd0);
    run(1'b0, 32'd6, 32'd7, 32'd0, 32'd42,
        34, 1'b0, 1'b0, "mul_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
